// File: rtl/rr_arbiter_4.sv
// Four-way round-robin arbiter with request/done handshake and optional hold timeout.
// Grant is a registered one-hot decode of {gnt_valid, gnt_idx}; a zero cycle separates grants.
module rr_arbiter_4 #(
    parameter int unsigned MAX_HOLD = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic [3:0] grant,
    output logic [1:0] gnt_idx,
    output logic       gnt_valid,
    output logic       timeout
);

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD > 0) ? (MAX_HOLD - 1) : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [1:0]       gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic             timeout_q, timeout_d;
    logic [3:0]       grant_q, grant_d;

    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic             found;
    logic             rel_hs;
    logic             expire;

    // First set request at or after ptr, wrapping modulo 4.
    always_comb begin
        pick_idx = ptr_q;
        cand     = ptr_q;
        found    = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cand = ptr_q + 2'(i);
            if (!found && req[cand]) begin
                pick_idx = cand;
                found    = 1'b1;
            end
        end
    end

    // Next-state and output computation.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        hold_cnt_d  = hold_cnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        timeout_d   = 1'b0;
        rel_hs      = done || !req[gnt_idx_q];
        expire      = (MAX_HOLD != 0) && (hold_cnt_q == HOLD_LAST);

        unique case (state_q)
            IDLE: begin
                if (req != 4'b0000) begin
                    gnt_idx_d   = pick_idx;
                    gnt_valid_d = 1'b1;
                    hold_cnt_d  = '0;
                    state_d     = BUSY;
                end
            end
            BUSY: begin
                if (rel_hs || expire) begin
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q + 2'd1;
                    timeout_d   = expire && !rel_hs;
                    state_d     = IDLE;
                end else if (hold_cnt_q != CNT_MAX) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        grant_d = gnt_valid_d ? (4'b0001 << gnt_idx_d) : 4'b0000;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            ptr_q       <= 2'd0;
            hold_cnt_q  <= '0;
            gnt_idx_q   <= 2'd0;
            gnt_valid_q <= 1'b0;
            timeout_q   <= 1'b0;
            grant_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            hold_cnt_q  <= hold_cnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            timeout_q   <= timeout_d;
            grant_q     <= grant_d;
        end
    end

    assign grant     = grant_q;
    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign timeout   = timeout_q;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Directed-vector bench for rr_arbiter_4 (MAX_HOLD=4) with hand-computed expectations.
module tb_rr_arbiter_4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic [3:0] grant;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       timeout;

    int n_vec;
    int n_err;

    rr_arbiter_4 #(.MAX_HOLD(4), .CNT_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .done      (done),
        .grant     (grant),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [3:0] rot_exp [9];

    initial begin
        n_vec = 0;
        n_err = 0;
        rot_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                    4'b0000, 4'b1000, 4'b0000, 4'b0001};

        // Reset held two cycles with all requests active.
        rst = 1'b1; req = 4'b1111; done = 1'b0;
        for (int c = 0; c < 2; c++) begin
            tick();
            chk("rst_grant", 8'(grant), 8'h0);
            chk("rst_valid", 8'(gnt_valid), 8'h0);
            chk("rst_idx", 8'(gnt_idx), 8'h0);
            chk("rst_timeout", 8'(timeout), 8'h0);
        end
        rst = 1'b0; req = 4'b0000;
        tick();
        chk("idle_grant", 8'(grant), 8'h0);

        // Rotation: all requests held, done pulsed on each grant.
        req = 4'b1111;
        for (int k = 0; k < 9; k++) begin
            tick();
            chk($sformatf("rot%0d", k), 8'(grant), 8'(rot_exp[k]));
            done = (grant != 4'b0000);
        end
        req = 4'b0000; done = 1'b1;
        tick();
        done = 1'b0;
        chk("rot_end_grant", 8'(grant), 8'h0);
        chk("rot_end_ptr", 8'(dut.ptr_q), 8'd1);

        // Single request for index 2.
        req = 4'b0100;
        tick();
        chk("single_grant", 8'(grant), 8'b0100);
        chk("single_idx", 8'(gnt_idx), 8'd2);
        done = 1'b1;
        tick();
        done = 1'b0; req = 4'b0000;
        chk("single_rel", 8'(grant), 8'h0);
        chk("single_ptr", 8'(dut.ptr_q), 8'd3);

        // Wrap/skip: ptr=3, req=0011 selects index 0.
        req = 4'b0011;
        tick();
        chk("wrap_grant", 8'(grant), 8'b0001);
        chk("wrap_idx", 8'(gnt_idx), 8'd0);
        req = 4'b0000;
        tick();
        chk("withdraw_grant", 8'(grant), 8'h0);
        chk("withdraw_timeout", 8'(timeout), 8'h0);

        // Timeout: grant held four cycles, then revoked with a one-cycle pulse.
        req = 4'b0001;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk($sformatf("hold%0d_grant", c), 8'(grant), 8'b0001);
            chk($sformatf("hold%0d_timeout", c), 8'(timeout), 8'h0);
        end
        tick();
        chk("to_grant", 8'(grant), 8'h0);
        chk("to_pulse", 8'(timeout), 8'h1);
        chk("to_valid", 8'(gnt_valid), 8'h0);
        tick();
        chk("regrant", 8'(grant), 8'b0001);
        chk("regrant_timeout", 8'(timeout), 8'h0);

        // Same hold, but done coincides with expiry on the fourth cycle.
        for (int c = 1; c < 4; c++) begin
            tick();
            chk($sformatf("hold2_%0d", c), 8'(grant), 8'b0001);
        end
        done = 1'b1;
        tick();
        done = 1'b0;
        chk("coinc_grant", 8'(grant), 8'h0);
        chk("coinc_timeout", 8'(timeout), 8'h0);

        // Reset mid-grant while index 3 owns the resource.
        req = 4'b1000;
        tick();
        chk("mid_grant", 8'(grant), 8'b1000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_grant", 8'(grant), 8'h0);
        chk("mid_rst_ptr", 8'(dut.ptr_q), 8'd0);
        chk("mid_rst_idx", 8'(gnt_idx), 8'd0);
        req = 4'b1001;
        tick();
        chk("post_rst_grant", 8'(grant), 8'b0001);
        chk("post_rst_idx", 8'(gnt_idx), 8'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
